// File: rtl/adc_seq_ctrl.sv
// ADC sequencer bring-up, readback confirmation, stall restart and single-channel sample capture.
// States: IDLE wait for enable+lock | WAIT start delay | WRITE_RUN/READ/CHECK arm+confirm | RUN capture | STOP halt | ERROR sticky fail
module adc_seq_ctrl #(
    parameter int SAMPLE_CHANNEL = 1,
    parameter int START_DELAY    = 1024,
    parameter int TIMEOUT        = 4096,
    parameter int MAX_RETRY      = 3
) (
    input  logic        clock_clk,
    input  logic        reset_sink_reset,
    input  logic        enable,
    input  logic        pll_locked,
    output logic        csr_address,
    output logic        csr_read,
    output logic        csr_write,
    output logic [31:0] csr_writedata,
    input  logic [31:0] csr_readdata,
    input  logic        resp_valid,
    input  logic [4:0]  resp_channel,
    input  logic [11:0] resp_data,
    output logic        sample_valid,
    output logic [15:0] sample_data,
    output logic        running,
    output logic        error
);

    localparam int CNT_MAX = (START_DELAY > TIMEOUT) ? START_DELAY : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(MAX_RETRY + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_WRITE_RUN,
        S_READ,
        S_CHECK,
        S_RUN,
        S_STOP,
        S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   retry_q, retry_d, retry_inc;
    logic            restart_q, restart_d;
    logic            running_q, running_d;
    logic            error_q, error_d;
    logic            sample_valid_q, sample_valid_d;
    logic [15:0]     sample_data_q, sample_data_d;
    logic            sample_hit;
    logic [15:0]     sample_conv;
    logic            unused_readdata;

    assign unused_readdata = ^csr_readdata[31:1];

    assign sample_hit = (state_q == S_RUN) && resp_valid && (resp_channel == 5'(SAMPLE_CHANNEL));
    // Subtracting mid-scale from an offset-binary code is just an MSB flip.
    assign sample_conv = {~resp_data[11], resp_data[10:0], 4'b0000};
    assign retry_inc = (retry_q == RW'(MAX_RETRY)) ? retry_q : retry_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        cnt_d          = '0;
        retry_d        = retry_q;
        restart_d      = restart_q;
        running_d      = running_q;
        error_d        = error_q;
        sample_valid_d = sample_hit;
        sample_data_d  = sample_hit ? sample_conv : sample_data_q;
        csr_read       = 1'b0;
        csr_write      = 1'b0;
        csr_writedata  = 32'h0000_0000;

        case (state_q)
            S_IDLE: begin
                running_d = 1'b0;
                if (enable && pll_locked) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!(enable && pll_locked)) state_d = S_IDLE;
                else if (cnt_q == CW'(START_DELAY - 1)) state_d = S_WRITE_RUN;
                else cnt_d = cnt_q + 1'b1;
            end
            S_WRITE_RUN: begin
                csr_write     = 1'b1;
                csr_writedata = 32'h0000_0001;
                state_d       = S_READ;
            end
            S_READ: begin
                csr_read = 1'b1;
                state_d  = S_CHECK;
            end
            S_CHECK: begin
                if (csr_readdata[0]) begin
                    state_d   = S_RUN;
                    running_d = 1'b1;
                    retry_d   = '0;
                end else begin
                    retry_d = retry_inc;
                    if (retry_inc >= RW'(MAX_RETRY)) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_WRITE_RUN;
                    end
                end
            end
            S_RUN: begin
                // Disable has priority so a coincident timeout never restarts.
                if (!enable || !pll_locked) begin
                    state_d   = S_STOP;
                    restart_d = 1'b0;
                    running_d = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = S_STOP;
                    restart_d = 1'b1;
                    running_d = 1'b0;
                end else begin
                    cnt_d = sample_hit ? '0 : cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                csr_write = 1'b1;
                restart_d = 1'b0;
                state_d   = (restart_q && enable) ? S_WRITE_RUN : S_IDLE;
            end
            S_ERROR: begin
                error_d   = 1'b1;
                running_d = 1'b0;
                if (!enable) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            retry_q        <= '0;
            restart_q      <= 1'b0;
            running_q      <= 1'b0;
            error_q        <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_data_q  <= 16'h0000;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            retry_q        <= retry_d;
            restart_q      <= restart_d;
            running_q      <= running_d;
            error_q        <= error_d;
            sample_valid_q <= sample_valid_d;
            sample_data_q  <= sample_data_d;
        end
    end

    assign csr_address  = 1'b0;
    assign sample_valid = sample_valid_q;
    assign sample_data  = sample_data_q;
    assign running      = running_q;
    assign error        = error_q;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Scoreboard bench for adc_seq_ctrl: startup, conversion, timeout, unlock, reset and retry/error scenarios.
module tb_adc_seq_ctrl;

    localparam int CH = 1;
    localparam int SD = 16;
    localparam int TO = 32;
    localparam int MR = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        pll_locked = 1'b0;
    logic        csr_address;
    logic        csr_read;
    logic        csr_write;
    logic [31:0] csr_writedata;
    logic [31:0] rd_val = 32'h0;
    logic        resp_valid = 1'b0;
    logic [4:0]  resp_channel = 5'd0;
    logic [11:0] resp_data = 12'd0;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        running;
    logic        error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    adc_seq_ctrl #(
        .SAMPLE_CHANNEL(CH),
        .START_DELAY(SD),
        .TIMEOUT(TO),
        .MAX_RETRY(MR)
    ) dut (
        .clock_clk(clk),
        .reset_sink_reset(rst),
        .enable(enable),
        .pll_locked(pll_locked),
        .csr_address(csr_address),
        .csr_read(csr_read),
        .csr_write(csr_write),
        .csr_writedata(csr_writedata),
        .csr_readdata(rd_val),
        .resp_valid(resp_valid),
        .resp_channel(resp_channel),
        .resp_data(resp_data),
        .sample_valid(sample_valid),
        .sample_data(sample_data),
        .running(running),
        .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (sample_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got data %h at cycle %0d, required no pulse", sample_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (sample_data !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL sample: got %h at cycle %0d, required %h at cycle %0d", sample_data, cyc, e.data, e.cyc);
                end
            end
        end
        checks++;
        if (csr_read && csr_write) begin
            errors++;
            $display("FAIL strobe_overlap: got read=1 write=1, required not both");
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send(input logic [4:0] ch, input logic [11:0] code, input bit fwd);
        exp_t e;
        resp_valid   = 1'b1;
        resp_channel = ch;
        resp_data    = code;
        if (fwd) begin
            e.data = 16'((int'(code) - 2048) * 16);
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({csr_read, csr_write, csr_writedata, csr_address, sample_valid, sample_data, running, error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%b wr=%b wd=%h sv=%b sd=%h run=%b err=%b, required all 0",
                     csr_read, csr_write, csr_writedata, sample_valid, sample_data, running, error);
        end
    endtask

    task automatic test_startup(input string tag);
        int n = 0;
        bit seen = 0;
        rst = 1'b0; enable = 1'b1; pll_locked = 1'b1; rd_val = 32'h1;
        while (!seen && n < 200) begin
            step();
            n++;
            if (csr_write) seen = 1;
        end
        checks++;
        if (n != SD + 1) begin
            errors++;
            $display("FAIL %s_delay: first write after %0d cycles, required %0d", tag, n, SD + 1);
        end
        checks++;
        if (csr_writedata !== 32'h1 || csr_read !== 1'b0) begin
            errors++;
            $display("FAIL %s_write: got wd=%h rd=%b, required wd=1 rd=0", tag, csr_writedata, csr_read);
        end
        step();
        checks++;
        if ({csr_read, csr_write} !== 2'b10) begin
            errors++;
            $display("FAIL %s_read: got rd=%b wr=%b, required rd=1 wr=0", tag, csr_read, csr_write);
        end
        step();
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL %s_check_state: got running=%b, required 0", tag, running);
        end
        step();
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL %s_running: got running=%b, required 1", tag, running);
        end
    endtask

    task automatic test_conversion();
        logic [11:0] codes[4] = '{12'd0, 12'd2048, 12'd4095, 12'd1};
        for (int i = 0; i < 4; i++) send(5'(CH), codes[i], 1'b1);
        send(5'd2, 12'd100, 1'b0);
        resp_valid = 1'b0;
        step();
        step();
        checks++;
        if (sample_data !== 16'h8010) begin
            errors++;
            $display("FAIL hold: got sample_data=%h, required 8010", sample_data);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL conv_drain: got %0d pending samples, required 0", exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int n;
        send(5'(CH), 12'd3000, 1'b1);
        resp_valid = 1'b0;
        n = 1;
        while (running && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n != TO + 1) begin
            errors++;
            $display("FAIL timeout_len: running dropped after %0d cycles, required %0d", n, TO + 1);
        end
        checks++;
        if (csr_write !== 1'b1 || csr_writedata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_stop: got wr=%b wd=%h, required wr=1 wd=0", csr_write, csr_writedata);
        end
        step();
        checks++;
        if (csr_write !== 1'b1 || csr_writedata !== 32'h1) begin
            errors++;
            $display("FAIL timeout_rewrite: got wr=%b wd=%h, required wr=1 wd=1", csr_write, csr_writedata);
        end
        step();
        checks++;
        if (csr_read !== 1'b1) begin
            errors++;
            $display("FAIL timeout_reread: got rd=%b, required 1", csr_read);
        end
        step();
        step();
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL timeout_rerun: got running=%b, required 1", running);
        end
        // a matching sample on the exact timeout cycle is forwarded and the exit still happens
        repeat (TO - 1) step();
        send(5'(CH), 12'd2048, 1'b1);
        resp_valid = 1'b0;
        checks++;
        if (running !== 1'b0 || csr_write !== 1'b1) begin
            errors++;
            $display("FAIL timeout_edge: got running=%b wr=%b, required running=0 wr=1", running, csr_write);
        end
        repeat (4) step();
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL timeout_edge_rerun: got running=%b, required 1", running);
        end
    endtask

    task automatic test_unlock();
        int writes = 0;
        int pulses = 0;
        pll_locked = 1'b0;
        step();
        checks++;
        if (csr_write !== 1'b1 || csr_writedata !== 32'h0 || running !== 1'b0) begin
            errors++;
            $display("FAIL unlock_stop: got wr=%b wd=%h run=%b, required wr=1 wd=0 run=0", csr_write, csr_writedata, running);
        end
        for (int i = 0; i < 8; i++) begin
            send(5'(CH), 12'd5, 1'b0);
            if (csr_write) writes++;
            if (sample_valid) pulses++;
        end
        resp_valid = 1'b0;
        checks++;
        if (writes != 0 || pulses != 0) begin
            errors++;
            $display("FAIL unlock_idle: got %0d writes %0d pulses, required 0 and 0", writes, pulses);
        end
        test_startup("relock");
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        send(5'(CH), 12'd100, 1'b0);
        resp_valid = 1'b0;
        checks++;
        if ({csr_read, csr_write, csr_writedata, csr_address, sample_valid, sample_data, running, error} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: got rd=%b wr=%b sv=%b sd=%h run=%b err=%b, required all 0",
                     csr_read, csr_write, sample_valid, sample_data, running, error);
        end
        test_startup("after_run_reset");
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        checks++;
        if ({csr_read, csr_write, csr_writedata, csr_address, sample_valid, sample_data, running, error} !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait: got rd=%b wr=%b sv=%b run=%b err=%b, required all 0",
                     csr_read, csr_write, sample_valid, running, error);
        end
        test_startup("after_wait_reset");
    endtask

    task automatic test_retry_error();
        int writes = 0;
        int reads = 0;
        int n = 0;
        int late = 0;
        rst = 1'b1;
        step();
        rst = 1'b0; rd_val = 32'h0; enable = 1'b1; pll_locked = 1'b1;
        while (!error && n < SD + 40) begin
            step();
            n++;
            if (csr_write) writes++;
            if (csr_read) reads++;
        end
        checks++;
        if (writes != MR || reads != MR) begin
            errors++;
            $display("FAIL retry_pairs: got %0d writes %0d reads, required %0d each", writes, reads, MR);
        end
        checks++;
        if (error !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL error_state: got err=%b run=%b, required err=1 run=0", error, running);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (csr_write || csr_read) late++;
        end
        checks++;
        if (late != 0) begin
            errors++;
            $display("FAIL error_quiet: got %0d strobes in ERROR, required 0", late);
        end
        enable = 1'b0;
        repeat (3) step();
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL error_sticky: got err=%b after disable, required 1", error);
        end
        rst = 1'b1;
        step();
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL error_clear: got err=%b after reset, required 0", error);
        end
        rst = 1'b0;
    endtask

    initial begin
        step();
        test_reset();
        test_startup("startup");
        test_conversion();
        test_timeout();
        test_unlock();
        test_reset_mid();
        test_retry_error();
        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: got %0d pending samples, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_seq_ctrl.md
Name: adc_seq_ctrl

Overview:
- Control and capture block for the on-chip modular ADC core.
- After PLL lock it configures the ADC sequencer over its 1-bit-address Avalon-MM CSR: continuous mode, run bit set, confirmed by readback.
- It then filters the ADC response stream for one channel, converts each 12-bit code to signed 16-bit audio, and restarts the sequencer if conversions stall.
- Sits between the ADC IP and the guitar effects datapath.

Parameters:
- SAMPLE_CHANNEL, 1, ADC response channel number to forward.
- START_DELAY, 1024, cycles to wait after pll_locked before the first CSR write.
- TIMEOUT, 4096, cycles without a matching sample before a sequencer restart.
- MAX_RETRY, 3, failed readback attempts before entering ERROR.

Ports:
- clock_clk  in  1  system clock, same clock as the ADC CSR/response interfaces.
- reset_sink_reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = acquire; 0 = stop the sequencer.
- pll_locked  in  1  ADC PLL locked.
- csr_address  out  1  sequencer CSR address, always 0.
- csr_read  out  1  CSR read strobe.
- csr_write  out  1  CSR write strobe.
- csr_writedata  out  32  CSR write data.
- csr_readdata  in  32  CSR read data, valid exactly 1 cycle after csr_read.
- resp_valid  in  1  ADC response valid.
- resp_channel  in  5  ADC response channel.
- resp_data  in  12  ADC response code, unsigned.
- sample_valid  out  1  1-cycle pulse, new sample available.
- sample_data  out  16  signed sample.
- running  out  1  sequencer confirmed running.
- error  out  1  sticky configuration failure.

Behaviour:
- Clock and reset:
  - One clock domain: clock_clk.
  - Reset is synchronous and active-high (reset_sink_reset); it takes effect at the next clock edge and overrides all other inputs.
  - Reset values: csr_read=0, csr_write=0, csr_writedata=0, csr_address=0, sample_valid=0, sample_data=0, running=0, error=0. State=IDLE, all counters=0.
- States:
  - IDLE: enter WAIT when enable=1 and pll_locked=1.
  - WAIT: count START_DELAY cycles. pll_locked or enable dropping returns to IDLE and clears the counter.
  - WRITE_RUN: 1-cycle pulse csr_write=1, csr_writedata=32'h0000_0001 (mode[3:1]=0 continuous, run[0]=1). Next state READ.
  - READ: 1-cycle pulse csr_read=1. Next state CHECK.
  - CHECK: sample csr_readdata.
    - Bit0=1: go to RUN, set running=1, clear the retry count.
    - Bit0=0: increment the retry count. If the count has reached MAX_RETRY, go to ERROR; otherwise return to WRITE_RUN.
  - RUN:
    - Forward samples.
    - The timeout counter increments each cycle and resets on every matching sample.
    - When the counter reaches TIMEOUT-1: go to STOP with restart flag=1 and clear running.
    - enable=0 or pll_locked=0: go to STOP with restart flag=0 and clear running.
  - STOP: 1-cycle pulse csr_write=1, csr_writedata=0.
    - Restart flag=1 and enable=1: go to WRITE_RUN. The retry count is not cleared.
    - Otherwise go to IDLE.
  - ERROR:
    - error=1 and running=0; no CSR traffic.
    - Leave only via reset, or via enable going 0 (then go to IDLE with error still set). Error is cleared only by reset.
- CSR strobes: read and write are never asserted together, and each strobe lasts exactly one cycle.
- Sample path (active only in RUN):
  - On resp_valid=1 and resp_channel==SAMPLE_CHANNEL, the next cycle has sample_valid=1 and sample_data=({1'b0,resp_data}-13'd2048)<<4, truncated to 16 bits.
  - Mapping: code 0 -> 16'h8000, 2048 -> 16'h0000, 4095 -> 16'h7FF0.
  - Latency is 1 cycle.
  - sample_data holds its value between pulses.
- Non-matching channels and responses outside RUN are dropped.
- Back-to-back valid responses each produce a pulse; there is no backpressure.
- A matching response in the same cycle as a timeout-triggered exit to STOP is forwarded. The exit still happens, because the timeout decision uses the counter value before the update.
- A timeout restart that is confirmed by readback keeps the cumulative retry count until it is cleared on the next successful CHECK.

Test Plan:
- Startup: reset, then enable=1, pll_locked=1, readdata=1 -> exactly START_DELAY wait cycles, then a write of 0x1, read 1 cycle later, running=1 2 cycles after the read.
- Conversion: in RUN, drive channel 1 with codes 0, 2048, 4095, 1 on consecutive cycles -> 4 consecutive pulses with data 0x8000, 0x0000, 0x7FF0, 0x8010. Channel 2 with code 100 -> no pulse.
- Retry and error: readdata=0 always, MAX_RETRY=3 -> exactly 3 write/read pairs, then error=1, running=0, no further strobes. enable=0 -> IDLE with error still 1. Reset -> error=0.
- Timeout: in RUN, no responses for TIMEOUT cycles -> running drops, write of 0 then write of 0x1 and a read; readdata=1 -> running=1 again.
- Disable/unlock: pll_locked=0 mid-RUN -> one write of 0, IDLE, sample_valid stays 0. Relock with enable=1 -> the full START_DELAY sequence repeats.
- Reset mid-WAIT and mid-RUN -> all outputs 0 on the next cycle; the following enable restarts from IDLE.
